// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Package pipe_ctrl_pkg: shared encodings for the 5-stage pipeline
// stall/flush sequencer.
//   state_e     : sequencer states (RUN / BR_STALL / MEM_WAIT)
//   OP_*        : ID/EX op codes for the memory and branch instructions
//   M_*_BIT     : bit positions inside the ID/EX M control field
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_BR_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  localparam logic [3:0] OP_LD  = 4'b0101;
  localparam logic [3:0] OP_SD  = 4'b0110;
  localparam logic [3:0] OP_BEQ = 4'b0111;

  localparam int M_READ_BIT   = 2;
  localparam int M_WRITE_BIT  = 1;
  localparam int M_BRANCH_BIT = 0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Interface pipeline_hazard_ctrl_if: hazard inputs from the ID and ID/EX
// stages, the data-memory handshake, and the per-register enables/bubbles
// returned to the pipeline.
//   master : pipeline side (drives *_i, observes *_o)
//   slave  : the hazard controller
// With PIPE_PERF_CNT_EN defined, stall_cnt_o and flush_cnt_o are added.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rs2_i;
  logic        id_uses_rs2_i;
  logic        id_is_branch_i;
  logic        branch_taken_i;
  logic [4:0]  ex_rd_i;
  logic        ex_mem_read_i;
  logic        ex_reg_write_i;
  logic        dmem_req_i;
  logic        dmem_ack_i;
  logic        pc_we_o;
  logic        if_id_we_o;
  logic        if_id_flush_o;
  logic        id_ex_we_o;
  logic        id_ex_bubble_o;
  logic        ex_mem_we_o;
  logic        mem_wb_bubble_o;
  logic [1:0]  state_o;
  logic        err_o;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;
`endif

  modport master (
    output id_rs1_i, id_rs2_i, id_uses_rs2_i, id_is_branch_i, branch_taken_i,
           ex_rd_i, ex_mem_read_i, ex_reg_write_i, dmem_req_i, dmem_ack_i,
    input  pc_we_o, if_id_we_o, if_id_flush_o, id_ex_we_o, id_ex_bubble_o,
           ex_mem_we_o, mem_wb_bubble_o, state_o, err_o
`ifdef PIPE_PERF_CNT_EN
    , input stall_cnt_o, flush_cnt_o
`endif
  );

  modport slave (
    input  id_rs1_i, id_rs2_i, id_uses_rs2_i, id_is_branch_i, branch_taken_i,
           ex_rd_i, ex_mem_read_i, ex_reg_write_i, dmem_req_i, dmem_ack_i,
    output pc_we_o, if_id_we_o, if_id_flush_o, id_ex_we_o, id_ex_bubble_o,
           ex_mem_we_o, mem_wb_bubble_o, state_o, err_o
`ifdef PIPE_PERF_CNT_EN
    , output stall_cnt_o, flush_cnt_o
`endif
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_cmp.sv
// hazard_cmp: combinational register-field comparator.
//   i_id_rs1/i_id_rs2/i_id_uses_rs2 : source registers of the ID instruction
//   i_id_is_branch                  : ID instruction is beq
//   i_ex_rd/i_ex_mem_read/i_ex_reg_write : destination and control in ID/EX
//   o_lu     : load-use hazard
//   o_br_alu : beq needs an ALU result still in EX
//   o_br_ld  : beq needs a load result still in EX (two stall cycles)
module hazard_cmp (
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_uses_rs2,
  input  logic       i_id_is_branch,
  input  logic [4:0] i_ex_rd,
  input  logic       i_ex_mem_read,
  input  logic       i_ex_reg_write,
  output logic       o_lu,
  output logic       o_br_alu,
  output logic       o_br_ld
);
  logic w_hit;

  // x0 is never a real producer, so a zero rd can not create a hazard.
  assign w_hit    = (i_ex_rd != 5'd0) &&
                    ((i_ex_rd == i_id_rs1) || (i_id_uses_rs2 && (i_ex_rd == i_id_rs2)));
  assign o_lu     = i_ex_mem_read & w_hit;
  assign o_br_alu = i_id_is_branch & i_ex_reg_write & ~i_ex_mem_read & w_hit;
  assign o_br_ld  = i_id_is_branch & o_lu;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
//   clk_i, rst_i : clock (rising edge), asynchronous active-high reset
//   bus (slave)  : hazard inputs, dmem handshake, enables/bubbles,
//                  state_o (current state), err_o (sticky memory timeout)
// Only the state, return state, timeout counter and error flag are stored;
// every enable, bubble and flush is decoded combinationally.
// Optional macro PIPE_PERF_CNT_EN adds stall and flush event counters.
import pipe_ctrl_pkg::*;

module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input logic clk_i,
  input logic rst_i,
  pipeline_hazard_ctrl_if.slave bus
);
  state_e           r_state;
  state_e           r_ret_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  logic w_lu, w_br_alu, w_br_ld;
  logic w_freeze, w_stall, w_flush, w_timeout;

  hazard_cmp u_hazard_cmp (
    .i_id_rs1      (bus.id_rs1_i),
    .i_id_rs2      (bus.id_rs2_i),
    .i_id_uses_rs2 (bus.id_uses_rs2_i),
    .i_id_is_branch(bus.id_is_branch_i),
    .i_ex_rd       (bus.ex_rd_i),
    .i_ex_mem_read (bus.ex_mem_read_i),
    .i_ex_reg_write(bus.ex_reg_write_i),
    .o_lu          (w_lu),
    .o_br_alu      (w_br_alu),
    .o_br_ld       (w_br_ld)
  );

  // An ack releases the freeze in the same cycle, so the hazard terms below
  // are evaluated normally on the ack cycle even while still in MEM_WAIT.
  always_comb begin
    w_freeze  = ~bus.dmem_ack_i & (bus.dmem_req_i | (r_state == ST_MEM_WAIT));
    w_stall   = ~w_freeze & ((r_state == ST_BR_STALL) | w_lu | w_br_alu | w_br_ld);
    w_flush   = ~w_freeze & ~w_stall & bus.id_is_branch_i & bus.branch_taken_i;
    w_timeout = (r_state == ST_MEM_WAIT) && (r_cnt == CNT_W'(MEM_TIMEOUT - 1));
  end

  assign bus.pc_we_o         = ~w_freeze & ~w_stall;
  assign bus.if_id_we_o      = ~w_freeze & ~w_stall;
  assign bus.if_id_flush_o   = w_flush;
  assign bus.id_ex_we_o      = ~w_freeze;
  assign bus.id_ex_bubble_o  = w_stall;
  assign bus.ex_mem_we_o     = ~w_freeze;
  assign bus.mem_wb_bubble_o = w_freeze;
  assign bus.state_o         = r_state;
  assign bus.err_o           = r_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_RUN;
      r_ret_state <= ST_RUN;
      r_cnt       <= '0;
      r_err       <= 1'b0;
    end else if (w_freeze) begin
      if (r_state != ST_MEM_WAIT) begin
        // Remember whether the pending BR_STALL cycle still has to happen.
        r_ret_state <= r_state;
        r_cnt       <= '0;
        r_state     <= ST_MEM_WAIT;
      end else if (w_timeout) begin
        r_err   <= 1'b1;
        r_state <= ST_RUN;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else begin
      case (r_state)
        ST_MEM_WAIT: r_state <= ((r_ret_state == ST_BR_STALL) || w_br_ld) ? ST_BR_STALL : ST_RUN;
        ST_BR_STALL: r_state <= ST_RUN;
        default:     r_state <= w_br_ld ? ST_BR_STALL : ST_RUN;
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!bus.pc_we_o) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_flush)      r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign bus.stall_cnt_o = r_stall_cnt;
  assign bus.flush_cnt_o = r_flush_cnt;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Inputs change on the falling edge
// and outputs are sampled 1 time unit later, well away from the rising edge.
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks   = 0;
  int failures = 0;

  // Expected control word: {pc_we, if_id_we, flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_bubble}
  localparam logic [6:0] NORM   = 7'b1101010;
  localparam logic [6:0] STALL  = 7'b0001110;
  localparam logic [6:0] FLUSH  = 7'b1111010;
  localparam logic [6:0] FREEZE = 7'b0000001;

  pipeline_hazard_ctrl_if bus ();

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic idle();
    bus.id_rs1_i       = 5'd0;
    bus.id_rs2_i       = 5'd0;
    bus.id_uses_rs2_i  = 1'b0;
    bus.id_is_branch_i = 1'b0;
    bus.branch_taken_i = 1'b0;
    bus.ex_rd_i        = 5'd0;
    bus.ex_mem_read_i  = 1'b0;
    bus.ex_reg_write_i = 1'b0;
    bus.dmem_req_i     = 1'b0;
    bus.dmem_ack_i     = 1'b0;
  endtask

  task automatic ex_clear();
    bus.ex_rd_i        = 5'd0;
    bus.ex_mem_read_i  = 1'b0;
    bus.ex_reg_write_i = 1'b0;
  endtask

  task automatic check(input string tag, input logic [6:0] ctl, input logic err, input logic [1:0] st);
    logic [9:0] obs;
    logic [9:0] exp;
    obs = {bus.pc_we_o, bus.if_id_we_o, bus.if_id_flush_o, bus.id_ex_we_o, bus.id_ex_bubble_o,
           bus.ex_mem_we_o, bus.mem_wb_bubble_o, bus.err_o, bus.state_o};
    exp = {ctl, err, st};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    idle();
    @(negedge clk); #1 check("reset", NORM, 1'b0, 2'd0);
    rst = 1'b0;
    @(negedge clk); #1 check("idle", NORM, 1'b0, 2'd0);

    // ld x5 in EX, add reading x5 in ID: one bubble, state stays RUN
    @(negedge clk);
    bus.ex_rd_i = 5'd5; bus.ex_mem_read_i = 1'b1; bus.ex_reg_write_i = 1'b1; bus.id_rs1_i = 5'd5;
    #1 check("lu_stall", STALL, 1'b0, 2'd0);
    @(negedge clk); ex_clear();
    #1 check("lu_resume", NORM, 1'b0, 2'd0);

    // ld x0 never stalls
    @(negedge clk);
    bus.ex_rd_i = 5'd0; bus.ex_mem_read_i = 1'b1; bus.ex_reg_write_i = 1'b1; bus.id_rs1_i = 5'd0;
    #1 check("ld_x0", NORM, 1'b0, 2'd0);

    // rs2 match counts only when the ID instruction reads rs2
    @(negedge clk); idle();
    bus.ex_rd_i = 5'd7; bus.ex_mem_read_i = 1'b1; bus.id_rs1_i = 5'd1; bus.id_rs2_i = 5'd7;
    #1 check("rs2_unused", NORM, 1'b0, 2'd0);
    @(negedge clk); bus.id_uses_rs2_i = 1'b1;
    #1 check("rs2_used", STALL, 1'b0, 2'd0);

    // ld x6 in EX, taken beq reading rs2=x6: two stalls, then the flush
    @(negedge clk); idle();
    bus.ex_rd_i = 5'd6; bus.ex_mem_read_i = 1'b1; bus.ex_reg_write_i = 1'b1;
    bus.id_is_branch_i = 1'b1; bus.id_uses_rs2_i = 1'b1; bus.id_rs1_i = 5'd2; bus.id_rs2_i = 5'd6;
    bus.branch_taken_i = 1'b1;
    #1 check("brld_stall1", STALL, 1'b0, 2'd0);
    @(negedge clk); ex_clear();
    #1 check("brld_stall2", STALL, 1'b0, 2'd1);
    @(negedge clk);
    #1 check("brld_flush", FLUSH, 1'b0, 2'd0);
    @(negedge clk); idle();
    #1 check("flush_once", NORM, 1'b0, 2'd0);

    // ALU producer for beq: one stall, state stays RUN
    @(negedge clk);
    bus.ex_rd_i = 5'd3; bus.ex_reg_write_i = 1'b1; bus.id_is_branch_i = 1'b1; bus.id_rs1_i = 5'd3;
    #1 check("bralu_stall", STALL, 1'b0, 2'd0);
    @(negedge clk); ex_clear();
    #1 check("bralu_resolve", NORM, 1'b0, 2'd0);

    // branch_taken without a branch in ID is ignored
    @(negedge clk); idle(); bus.branch_taken_i = 1'b1;
    #1 check("taken_nobr", NORM, 1'b0, 2'd0);

    // memory ack after 3 frozen cycles, ack cycle carries a load-use hazard
    @(negedge clk); idle(); bus.dmem_req_i = 1'b1;
    #1 check("mem_f1", FREEZE, 1'b0, 2'd0);
    @(negedge clk); #1 check("mem_f2", FREEZE, 1'b0, 2'd2);
    @(negedge clk); #1 check("mem_f3", FREEZE, 1'b0, 2'd2);
    @(negedge clk);
    bus.dmem_ack_i = 1'b1;
    bus.ex_rd_i = 5'd5; bus.ex_mem_read_i = 1'b1; bus.ex_reg_write_i = 1'b1; bus.id_rs1_i = 5'd5;
    #1 check("ack_lu", STALL, 1'b0, 2'd2);
    @(negedge clk); idle();
    #1 check("ack_ret_run", NORM, 1'b0, 2'd0);

    // freeze arriving during BR_STALL returns to BR_STALL after the ack
    @(negedge clk);
    bus.ex_rd_i = 5'd6; bus.ex_mem_read_i = 1'b1; bus.ex_reg_write_i = 1'b1;
    bus.id_is_branch_i = 1'b1; bus.id_rs1_i = 5'd6;
    #1 check("br2_stall", STALL, 1'b0, 2'd0);
    @(negedge clk); ex_clear(); bus.dmem_req_i = 1'b1;
    #1 check("brst_freeze", FREEZE, 1'b0, 2'd1);
    @(negedge clk); #1 check("brst_wait", FREEZE, 1'b0, 2'd2);
    @(negedge clk); bus.dmem_ack_i = 1'b1;
    #1 check("brst_ack", NORM, 1'b0, 2'd2);
    @(negedge clk); bus.dmem_req_i = 1'b0; bus.dmem_ack_i = 1'b0;
    #1 check("brst_ret", STALL, 1'b0, 2'd1);
    @(negedge clk); idle();
    #1 check("brst_done", NORM, 1'b0, 2'd0);

    // memory never acks: 16 MEM_WAIT cycles, then abort with err_o
    @(negedge clk); bus.dmem_req_i = 1'b1;
    #1 check("to_enter", FREEZE, 1'b0, 2'd0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); #1 check($sformatf("to_wait%0d", i), FREEZE, 1'b0, 2'd2);
    end
    @(negedge clk); #1 check("to_abort", FREEZE, 1'b1, 2'd0);
    @(negedge clk); bus.dmem_ack_i = 1'b1;
    #1 check("err_sticky", NORM, 1'b1, 2'd2);
    @(negedge clk); bus.dmem_req_i = 1'b0; bus.dmem_ack_i = 1'b0;
    #1 check("err_run", NORM, 1'b1, 2'd0);

    // reset pulsed in the middle of a wait takes effect immediately
    @(negedge clk); bus.dmem_req_i = 1'b1;
    #1 check("w2_enter", FREEZE, 1'b1, 2'd0);
    @(negedge clk); @(negedge clk);
    #1 check("w2_wait", FREEZE, 1'b1, 2'd2);
    rst = 1'b1;
    #1 check("rst_async", FREEZE, 1'b0, 2'd0);
    bus.dmem_req_i = 1'b0;
    #1 check("rst_idle", NORM, 1'b0, 2'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1 check("post_rst", NORM, 1'b0, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
